// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART instruction-memory programmer.
// Holds the frame FSM and RX sampler state enums, error codes and frame bytes.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FRAME   = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // States in which a frame is in flight (timeout runs, imem is claimed).
  function automatic logic is_active(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/uart_imem_programmer_if.sv
// Instruction-memory write port driven by the programmer (master) into imem (slave).
// imem_we is a single-cycle strobe: din/addr are valid only in that cycle; there is no ready.
interface uart_imem_programmer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] imem_din;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic              imem_prog_ena;

  modport master (output imem_din, output imem_addr, output imem_we, output imem_prog_ena);
  modport slave  (input imem_din, input imem_addr, input imem_we, input imem_prog_ena);
endinterface

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 2-FF synchroniser, start re-check at half bit, centre sampling.
// byte_valid or frame_err pulses for one cycle right after the stop-bit sample.
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_t  dbg_state
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  rx_state_t     st;

  assign dbg_state = st;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      st         <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_d       <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (st)
        R_IDLE: if (rx_d && !rx_s) begin
          st  <= R_START;
          cnt <= '0;
        end
        R_START: if (cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
          // Line back high at mid start bit means a glitch, not a byte.
          cnt     <= '0;
          bit_idx <= '0;
          st      <= rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt <= cnt + CW'(1);
        end
        R_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt     <= '0;
          data    <= {rx_s, data[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) st <= R_STOP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        R_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt        <= '0;
          st         <= R_IDLE;
          byte_valid <= rx_s;
          frame_err  <= !rx_s;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_programmer.sv
// Framed UART program loader: A5, LEN(16b LE), N words LE, mod-256 data checksum.
// Define UART_ACK_EN to add a TX serialiser that answers 06 on success or 15,<err> on error.
module uart_imem_programmer
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_BYTES   = 4,
  parameter int ADDR_W       = 12,
  parameter int BASE_ADDR    = 0,
  parameter int MAX_WORDS    = 4096,
  parameter int TIMEOUT_CYC  = 2_000_000
) (
  input  logic                   clk,
  input  logic                   Rst_n,
  input  logic                   prog,
  input  logic                   rx,
  output logic                   tx,
  uart_imem_programmer_if.master imem,
  output logic                   prog_busy,
  output logic                   prog_done,
  output logic [2:0]             prog_err,
  output logic [ADDR_W:0]        words_written,
  output state_t                 dbg_state,
  output rx_state_t              dbg_rx_state
);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BCW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]        rx_byte;
  logic              byte_valid, frame_err;
  state_t            state;
  logic [DATA_W-1:0] word_sh, word_next, din;
  logic [BCW-1:0]    byte_cnt;
  logic [7:0]        len_lo, csum;
  logic [15:0]       n_rx, words_left;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]     tmo;
  logic              we, active;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .rx         (rx),
    .data       (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .dbg_state  (dbg_rx_state)
  );

  assign active             = is_active(state);
  assign prog_busy          = active;
  assign imem.imem_prog_ena = active;
  assign imem.imem_din      = din;
  assign imem.imem_addr     = addr;
  assign imem.imem_we       = we;
  assign dbg_state          = state;
  assign n_rx               = {rx_byte, len_lo};
  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign word_next          = (word_sh >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      word_sh       <= '0;
      din           <= '0;
      byte_cnt      <= '0;
      len_lo        <= '0;
      csum          <= '0;
      words_left    <= '0;
      addr          <= '0;
      tmo           <= '0;
      we            <= 1'b0;
      prog_done     <= 1'b0;
      prog_err      <= ERR_NONE;
      words_written <= '0;
    end else begin
      we        <= 1'b0;
      prog_done <= 1'b0;
      // Address/count advance after the strobe cycle so the write sees the current address.
      if (we) begin
        addr          <= addr + ADDR_W'(1);
        words_written <= words_written + (ADDR_W+1)'(1);
      end
      tmo <= (!active || byte_valid) ? '0 : tmo + TW'(1);

      if (!prog && state != IDLE) begin
        state <= IDLE;
      end else if (active && frame_err) begin
        state    <= ERR;
        prog_err <= ERR_FRAME;
      end else if (byte_valid) begin
        case (state)
          IDLE, DONE, ERR: if (prog && rx_byte == HDR_BYTE) begin
            state         <= LEN_LO;
            prog_err      <= ERR_NONE;
            words_written <= '0;
            csum          <= '0;
            byte_cnt      <= '0;
          end
          LEN_LO: begin
            len_lo <= rx_byte;
            state  <= LEN_HI;
          end
          LEN_HI: if (n_rx == 16'd0 || {1'b0, n_rx} > 17'(MAX_WORDS)) begin
            state    <= ERR;
            prog_err <= ERR_LEN;
          end else begin
            state      <= DATA;
            addr       <= ADDR_W'(BASE_ADDR);
            words_left <= n_rx;
          end
          DATA: begin
            word_sh <= word_next;
            csum    <= csum + rx_byte;
            if (byte_cnt == BCW'(WORD_BYTES - 1)) begin
              byte_cnt   <= '0;
              din        <= word_next;
              we         <= 1'b1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= CSUM;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
          CSUM: if (rx_byte == csum) begin
            state     <= DONE;
            prog_done <= 1'b1;
          end else begin
            state    <= ERR;
            prog_err <= ERR_CSUM;
          end
          default: state <= IDLE;
        endcase
      end else if (active && tmo == TW'(TIMEOUT_CYC - 1)) begin
        state    <= ERR;
        prog_err <= ERR_TIMEOUT;
      end
    end
  end

`ifdef UART_ACK_EN
  localparam int CW = $clog2(CLKS_PER_BIT);

  state_t        st_prev;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    tx_q0, tx_q1;
  logic [1:0]    tx_n;

  assign tx = (tx_bits != 4'd0) ? tx_sh[0] : 1'b1;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_prev <= IDLE;
      tx_sh   <= '1;
      tx_bits <= '0;
      tx_cnt  <= '0;
      tx_q0   <= '0;
      tx_q1   <= '0;
      tx_n    <= '0;
    end else begin
      st_prev <= state;
      if (tx_bits != 4'd0) begin
        if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          tx_cnt  <= '0;
          tx_sh   <= {1'b1, tx_sh[9:1]};
          tx_bits <= tx_bits - 4'd1;
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end else if (tx_n != 2'd0) begin
        tx_sh   <= {1'b1, tx_q0, 1'b0};
        tx_bits <= 4'd10;
        tx_cnt  <= '0;
        tx_q0   <= tx_q1;
        tx_n    <= tx_n - 2'd1;
      end
      // A fresh completion status replaces anything still queued.
      if (state == DONE && st_prev != DONE) begin
        tx_q0 <= ACK_BYTE;
        tx_n  <= 2'd1;
      end else if (state == ERR && st_prev != ERR) begin
        tx_q0 <= NAK_BYTE;
        tx_q1 <= {5'd0, prog_err};
        tx_n  <= 2'd2;
      end
    end
  end
`else
  assign tx = 1'b1;
`endif

endmodule
